// File: rtl/store_buffer.sv
// Posted-write store buffer between the MEM stage and data memory.
// Stores enqueue in one edge, loads forward from the youngest match, and the head drains when the port is free.
module store_buffer #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic              memRead_i,
    input  logic              memWrite_i,
    input  logic [DATA_W-1:0] Write_Data_i,
    output logic [DATA_W-1:0] Read_Data_o,
    output logic              stall_o,
    output logic              empty_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic              mem_read_o,
    output logic              mem_write_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] addr_mem_q [DEPTH];
    logic [DATA_W-1:0] data_mem_q [DEPTH];

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic              full;
    logic              is_store;
    logic              stall;
    logic              enq;
    logic              drain;
    logic              hit;
    logic [DATA_W-1:0] fwd_data;

    assign full     = (count_q == CNT_W'(DEPTH));
    assign is_store = memWrite_i & ~memRead_i;
    assign stall    = is_store & full;
    assign enq      = is_store & ~full;
    // A full-stall cycle doubles as a drain cycle so the held store fits next cycle.
    assign drain    = (count_q != '0) & ((~memRead_i & ~memWrite_i) | stall);

    // Scan oldest to youngest so the last match (closest to tail) wins.
    always_comb begin
        logic [PTR_W-1:0] idx;
        idx      = '0;
        hit      = 1'b0;
        fwd_data = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            idx = head_q + PTR_W'(i);
            if ((CNT_W'(i) < count_q) && (addr_mem_q[idx] == addr_i)) begin
                hit      = 1'b1;
                fwd_data = data_mem_q[idx];
            end
        end
    end

    always_comb begin
        Read_Data_o = '0;
        mem_read_o  = 1'b0;
        mem_write_o = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        if (memRead_i) begin
            if (hit) begin
                Read_Data_o = fwd_data;
            end else begin
                Read_Data_o = mem_rdata_i;
                mem_read_o  = 1'b1;
                mem_addr_o  = addr_i;
            end
        end else if (drain) begin
            mem_write_o = 1'b1;
            mem_addr_o  = addr_mem_q[head_q];
            mem_wdata_o = data_mem_q[head_q];
        end
    end

    assign stall_o = stall;
    assign empty_o = (count_q == '0);

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (enq) begin
            tail_d  = tail_q + 1'b1;
            count_d = count_q + 1'b1;
        end else if (drain) begin
            head_d  = head_q + 1'b1;
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (enq) begin
            addr_mem_q[tail_q] <= addr_i;
            data_mem_q[tail_q] <= Write_Data_i;
        end
    end

endmodule

// File: tb/tb_store_buffer.sv
// Directed and random checks of store_buffer against a queue-based reference model.
module tb_store_buffer;

    localparam int DEPTH = 4;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic [31:0] addr_i = '0;
    logic        memRead_i = 1'b0;
    logic        memWrite_i = 1'b0;
    logic [31:0] Write_Data_i = '0;
    logic [31:0] Read_Data_o;
    logic        stall_o;
    logic        empty_o;
    logic [31:0] mem_addr_o;
    logic        mem_read_o;
    logic        mem_write_o;
    logic [31:0] mem_wdata_o;
    logic [31:0] mem_rdata_i = '0;

    int tests = 0;
    int fails = 0;
    int stepno = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
    } ent_t;
    ent_t sb[$];

    store_buffer #(.DEPTH(DEPTH), .ADDR_W(32), .DATA_W(32)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .addr_i(addr_i),
        .memRead_i(memRead_i), .memWrite_i(memWrite_i), .Write_Data_i(Write_Data_i),
        .Read_Data_o(Read_Data_o), .stall_o(stall_o), .empty_o(empty_o),
        .mem_addr_o(mem_addr_o), .mem_read_o(mem_read_o), .mem_write_o(mem_write_o),
        .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // One cycle: drive, check combinational outputs against the model, clock, update model.
    task automatic step(input logic rd, input logic wr, input logic [31:0] a,
                        input logic [31:0] d, input logic [31:0] rdata);
        logic        full, hit, drn;
        logic [31:0] fwd;
        string       s;
        stepno++;
        s = $sformatf("s%0d", stepno);
        if (rd && wr) $display("[TB] note: step %0d drives illegal load+store", stepno);
        memRead_i = rd; memWrite_i = wr; addr_i = a; Write_Data_i = d; mem_rdata_i = rdata;
        full = (sb.size() == DEPTH);
        hit  = 1'b0;
        fwd  = '0;
        foreach (sb[i]) if (sb[i].a == a) begin hit = 1'b1; fwd = sb[i].d; end
        drn = (sb.size() > 0) && ((!rd && !wr) || (!rd && wr && full));
        #2;
        chk({s, " empty"}, 32'(empty_o), 32'(sb.size() == 0));
        chk({s, " stall"}, 32'(stall_o), 32'(!rd && wr && full));
        chk({s, " mwrite"}, 32'(mem_write_o), 32'(drn));
        if (rd) begin
            chk({s, " rdata"}, Read_Data_o, hit ? fwd : rdata);
            chk({s, " mread"}, 32'(mem_read_o), 32'(!hit));
            if (!hit) chk({s, " maddr"}, mem_addr_o, a);
        end else begin
            chk({s, " rdata0"}, Read_Data_o, 32'h0);
            chk({s, " mread"}, 32'(mem_read_o), 32'h0);
            if (drn) begin
                chk({s, " daddr"}, mem_addr_o, sb[0].a);
                chk({s, " ddata"}, mem_wdata_o, sb[0].d);
            end else if (sb.size() == 0) begin
                chk({s, " iaddr"}, mem_addr_o, 32'h0);
                chk({s, " idata"}, mem_wdata_o, 32'h0);
            end
        end
        @(posedge clk_i);
        if (!rd && wr && !full) begin
            ent_t e;
            e.a = a; e.d = d;
            sb.push_back(e);
        end else if (drn) begin
            void'(sb.pop_front());
        end
        #1;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
    endtask

    initial begin
        int r;
        // Reset
        @(posedge clk_i); @(posedge clk_i);
        #2;
        chk("rst empty", 32'(empty_o), 32'h1);
        chk("rst stall", 32'(stall_o), 32'h0);
        chk("rst mwrite", 32'(mem_write_o), 32'h0);
        @(posedge clk_i); #1;
        rst_i = 1'b1;

        // 1: five back-to-back stores; fifth stalls while head drains, then retries
        for (int k = 1; k <= 5; k++) step(1'b0, 1'b1, 32'(k), 32'(k * 'h11), 32'h0);
        step(1'b0, 1'b1, 32'd5, 32'h55, 32'h0);
        for (int k = 0; k < 5; k++) idle();

        // 2 and 4: duplicate-address forwarding, then in-order drain
        step(1'b0, 1'b1, 32'd7, 32'hAAAA, 32'h0);
        step(1'b0, 1'b1, 32'd7, 32'hBBBB, 32'h0);
        step(1'b1, 1'b0, 32'd7, 32'h0, 32'hDEAD);
        idle(); idle();
        step(1'b1, 1'b0, 32'd7, 32'h0, 32'hC0DE);

        // 3: load miss with the buffer holding another address
        step(1'b0, 1'b1, 32'd3, 32'h3333, 32'h0);
        step(1'b1, 1'b0, 32'd9, 32'h0, 32'h1234);
        step(1'b1, 1'b0, 32'd3, 32'h0, 32'h1234);
        idle(); idle();

        // 6: illegal load+store treated as a load
        step(1'b1, 1'b1, 32'd5, 32'h99, 32'h5A5A);
        step(1'b1, 1'b0, 32'd5, 32'h0, 32'h6B6B);
        idle();

        // 5: async reset mid-cycle while full and stalling
        for (int k = 0; k < 4; k++) step(1'b0, 1'b1, 32'(20 + k), 32'(k), 32'h0);
        memRead_i = 1'b0; memWrite_i = 1'b1; addr_i = 32'd30; Write_Data_i = 32'h30;
        #2;
        chk("pre-rst stall", 32'(stall_o), 32'h1);
        rst_i = 1'b0;
        #1;
        chk("async empty", 32'(empty_o), 32'h1);
        chk("async stall", 32'(stall_o), 32'h0);
        chk("async mwrite", 32'(mem_write_o), 32'h0);
        sb.delete();
        memWrite_i = 1'b0;
        @(posedge clk_i); #1;
        rst_i = 1'b1;
        for (int k = 0; k < 3; k++) idle();

        // Random traffic over a small address range to exercise hits and wrap
        for (int n = 0; n < 300; n++) begin
            r = int'($urandom_range(0, 9));
            if (r < 3)      step(1'b1, 1'b0, 32'($urandom_range(0, 7)), 32'h0, $urandom);
            else if (r < 7) step(1'b0, 1'b1, 32'($urandom_range(0, 7)), $urandom, 32'h0);
            else            idle();
        end
        for (int k = 0; k < DEPTH + 1; k++) idle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
